// File: rtl/fetch_align_buffer.sv
// Halfword realignment buffer between fetch and decode: joins halfwords into
// whole 16/32-bit instructions and presents up to LANES of them per cycle.
module fetch_align_buffer #(
  parameter int FETCH_WIDTH = 32,
  parameter int DEPTH       = 8,
  parameter int LANES       = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   fetch_valid,
  output logic                   fetch_ready,
  input  logic [FETCH_WIDTH-1:0] fetch_data,
  input  logic [31:0]            fetch_pc,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*32-1:0]    out_instr,
  output logic [LANES*32-1:0]    out_pc,
  output logic [LANES-1:0]       out_rvc,
  input  logic                   out_ready
);

  localparam int HW = FETCH_WIDTH / 16;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int OW = $clog2(HW);

  logic [15:0]   mem [DEPTH];
  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   head_pc;
  logic          need_pc;

  logic          enq;
  logic          deq;
  logic [OW-1:0] offset;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] used;

  logic [CW-1:0] pos;
  logic [CW-1:0] size;
  logic          chain;
  logic          rvc;
  logic [15:0]   lo;
  logic [15:0]   hi;

  function automatic logic is_rvc(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  // Ring indices wrap naturally because DEPTH is a power of two.
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base,
                                         input logic [CW-1:0] delta);
    return base + delta[IW-1:0];
  endfunction

  assign fetch_ready = (count <= CW'(DEPTH - HW));
  assign enq         = fetch_valid & fetch_ready & ~flush;
  assign deq         = out_ready & ~flush;
  assign offset      = need_pc ? fetch_pc[OW:1] : '0;
  assign in_cnt      = CW'(HW) - CW'(offset);
  assign out_cnt     = deq ? used : '0;

  // Lane decode: walk from head; a lane is only valid if every earlier lane is.
  always_comb begin
    out_valid = '0;
    out_instr = '0;
    out_pc    = '0;
    out_rvc   = '0;
    pos       = '0;
    size      = '0;
    chain     = 1'b1;
    rvc       = 1'b0;
    lo        = '0;
    hi        = '0;
    for (int l = 0; l < LANES; l++) begin
      lo   = mem[wrap(head, pos)];
      hi   = mem[wrap(head, pos + CW'(1))];
      rvc  = is_rvc(lo);
      size = rvc ? CW'(1) : CW'(2);
      if (chain && (count >= pos + size)) begin
        out_valid[l]        = 1'b1;
        out_rvc[l]          = rvc;
        out_instr[l*32+:32] = rvc ? {16'h0000, lo} : {hi, lo};
        out_pc[l*32+:32]    = head_pc + 32'({pos, 1'b0});
        pos                 = pos + size;
      end else begin
        chain = 1'b0;
      end
    end
    used = pos;
  end

  // On the first word after reset/flush, halfwords below the PC offset are dropped.
  always_ff @(posedge clock) begin
    if (enq) begin
      for (int i = 0; i < HW; i++) begin
        if (CW'(i) >= CW'(offset))
          mem[wrap(tail, CW'(i) - CW'(offset))] <= fetch_data[16*i+:16];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      head_pc <= '0;
      need_pc <= 1'b1;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      need_pc <= 1'b1;
    end else begin
      head  <= wrap(head, out_cnt);
      count <= count + (enq ? in_cnt : CW'(0)) - out_cnt;
      if (enq)
        tail <= wrap(tail, in_cnt);
      if (enq && need_pc) begin
        head_pc <= fetch_pc;
        need_pc <= 1'b0;
      end else begin
        head_pc <= head_pc + 32'({out_cnt, 1'b0});
      end
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Randomized and directed bench for fetch_align_buffer against a queue-based
// model of the halfword stream.
module tb_fetch_align_buffer;

  localparam int FW    = 32;
  localparam int DEPTH = 8;
  localparam int LANES = 2;
  localparam int HW    = FW / 16;

  logic                clock = 1'b0;
  logic                reset;
  logic                flush;
  logic                fetch_valid;
  logic                fetch_ready;
  logic [FW-1:0]       fetch_data;
  logic [31:0]         fetch_pc;
  logic [LANES-1:0]    out_valid;
  logic [LANES*32-1:0] out_instr;
  logic [LANES*32-1:0] out_pc;
  logic [LANES-1:0]    out_rvc;
  logic                out_ready;

  always #5 clock = ~clock;

  fetch_align_buffer #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_data(fetch_data), .fetch_pc(fetch_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_rvc(out_rvc), .out_ready(out_ready)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] q[$];
  logic [31:0] mpc;
  bit          mneed;

  logic [LANES-1:0] exp_v;
  logic [31:0]      exp_i [LANES];
  logic [31:0]      exp_p [LANES];
  logic [LANES-1:0] exp_r;
  int               exp_used;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mpc   = 32'h0;
    mneed = 1'b1;
  endtask

  // Expected lanes straight from the halfword stream held in the queue.
  task automatic calc();
    int  idx;
    bit  ok;
    bit  r;
    int  sz;
    idx   = 0;
    ok    = 1'b1;
    exp_v = '0;
    exp_r = '0;
    for (int l = 0; l < LANES; l++) begin
      exp_i[l] = '0;
      exp_p[l] = '0;
      if (ok && idx < q.size()) begin
        r  = (q[idx][1:0] != 2'b11);
        sz = r ? 1 : 2;
        if (idx + sz <= q.size()) begin
          exp_v[l] = 1'b1;
          exp_r[l] = r;
          exp_i[l] = r ? {16'h0, q[idx]} : {q[idx+1], q[idx]};
          exp_p[l] = mpc + 32'(2 * idx);
          idx += sz;
        end else begin
          ok = 1'b0;
        end
      end else begin
        ok = 1'b0;
      end
    end
    exp_used = idx;
  endtask

  task automatic step();
    bit rdy;
    int off;
    #1;
    if (!reset) model_reset();
    calc();
    check("out_valid", 32'(out_valid), 32'(exp_v));
    check("fetch_ready", 32'(fetch_ready), 32'((DEPTH - q.size()) >= HW));
    for (int l = 0; l < LANES; l++) begin
      if (exp_v[l] || !reset) begin
        check($sformatf("instr%0d", l), out_instr[l*32+:32], exp_i[l]);
        check($sformatf("pc%0d", l), out_pc[l*32+:32], exp_p[l]);
        check($sformatf("rvc%0d", l), 32'(out_rvc[l]), 32'(exp_r[l]));
      end
    end
    @(posedge clock);
    rdy = ((DEPTH - q.size()) >= HW);
    if (!reset) begin
      model_reset();
    end else if (flush) begin
      q.delete();
      mneed = 1'b1;
    end else begin
      if (out_ready) begin
        repeat (exp_used) void'(q.pop_front());
        mpc = mpc + 32'(2 * exp_used);
      end
      if (fetch_valid && rdy) begin
        off = 0;
        if (mneed) begin
          mpc   = fetch_pc;
          off   = int'((fetch_pc >> 1) & 32'(HW - 1));
          mneed = 1'b0;
        end
        for (int i = off; i < HW; i++) q.push_back(fetch_data[16*i+:16]);
      end
    end
    @(negedge clock);
  endtask

  task automatic drive(input bit fv, input logic [31:0] d, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    fetch_valid = fv;
    fetch_data  = d;
    fetch_pc    = pc;
    out_ready   = ordy;
    flush       = fl;
  endtask

  int acc;

  initial begin
    model_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    @(negedge clock);

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      step();
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_ready", 32'(fetch_ready), 32'h1);
    end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) step();
    check("idle_valid", 32'(out_valid), 32'h0);
    check("idle_ready", 32'(fetch_ready), 32'h1);

    // Two RVC in one word
    drive(1, 32'h45014485, 32'h1000, 0, 0);
    step();
    drive(0, 0, 0, 1, 0);
    check("rvc2_v", 32'(out_valid), 32'h3);
    check("rvc2_i0", out_instr[31:0], 32'h00004485);
    check("rvc2_p0", out_pc[31:0], 32'h1000);
    check("rvc2_i1", out_instr[63:32], 32'h00004501);
    check("rvc2_p1", out_pc[63:32], 32'h1002);
    check("rvc2_r", 32'(out_rvc), 32'h3);
    step();
    check("rvc2_empty", 32'(out_valid), 32'h0);

    // Straddling 32-bit instruction
    drive(0, 0, 0, 0, 1);
    step();
    drive(1, 32'h05134485, 32'h2000, 0, 0);
    step();
    check("strad_v_a", 32'(out_valid), 32'h1);
    check("strad_i0", out_instr[31:0], 32'h00004485);
    drive(1, 32'h000000A0, 32'h0, 0, 0);
    step();
    check("strad_v_b", 32'(out_valid), 32'h3);
    check("strad_i1", out_instr[63:32], 32'h00A00513);
    check("strad_p1", out_pc[63:32], 32'h2002);
    check("strad_r1", 32'(out_rvc[1]), 32'h0);
    drive(0, 0, 0, 1, 0);
    step();
    check("strad_v_c", 32'(out_valid), 32'h1);
    check("strad_i0c", out_instr[31:0], 32'h0);
    check("strad_p0c", out_pc[31:0], 32'h2006);
    check("strad_r0c", 32'(out_rvc[0]), 32'h1);

    // Misaligned start after flush
    drive(0, 0, 0, 0, 1);
    step();
    drive(1, 32'h4501ABCD, 32'h3002, 0, 0);
    step();
    check("mis_v", 32'(out_valid), 32'h1);
    check("mis_i0", out_instr[31:0], 32'h00004501);
    check("mis_p0", out_pc[31:0], 32'h3002);

    // Fill to full under backpressure
    drive(0, 0, 0, 0, 1);
    step();
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h00010001, 32'h5000, 0, 0);
      if (fetch_ready) acc++;
      step();
    end
    check("full_acc", 32'(acc), 32'd4);
    check("full_ready", 32'(fetch_ready), 32'h0);
    drive(0, 0, 0, 1, 0);
    step();
    check("drain_ready", 32'(fetch_ready), 32'h1);
    check("drain_p0", out_pc[31:0], 32'h5004);

    // Flush colliding with fetch and dequeue
    drive(1, 32'h45014485, 32'h7000, 1, 1);
    step();
    check("fl_v", 32'(out_valid), 32'h0);
    check("fl_ready", 32'(fetch_ready), 32'h1);
    drive(1, 32'h45014485, 32'h4000, 0, 0);
    step();
    check("fl_p0", out_pc[31:0], 32'h4000);
    check("fl_v2", 32'(out_valid), 32'h3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] d;
      logic [31:0] pc;
      d  = $urandom;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hE) : ($urandom & ~32'h1);
      drive(($urandom_range(0, 3) != 0), d, pc, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 63) == 0));
      reset = ($urandom_range(0, 499) != 0);
      step();
      reset = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
